alu_sequencer: RTL and testbench

//  Two-requester front end for the shared combinational ALU (cmd 0 ADD, 1 SUB,
//  2 AND, 3 MP0, 4 MP1, 5 DV0, 6 DV1).

---
 rtl/alu_seq_pkg.sv | 51 +++++
 rtl/alu_sequencer_rr_arb2.sv | 28 ++
 rtl/alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the two-requester ALU sequencer.
// Op codes, ALU command encodings, FSM states and response fill values.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_MP0 = 3'd3,
        ALU_MP1 = 3'd4,
        ALU_DV0 = 3'd5,
        ALU_DV1 = 3'd6
    } alu_cmd_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC1 = 2'd1,
        S_EXEC2 = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [14:0] DIVZ_FILL = 15'h7FFF;
    localparam logic [14:0] ERR_FILL  = 15'h0000;

    function automatic logic is_two_pass(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic alu_cmd_e first_cmd(input logic [2:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_MUL:  return ALU_MP0;
            OP_DIV:  return ALU_DV0;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic alu_cmd_e second_cmd(input logic [2:0] op);
        return (op == OP_DIV) ? ALU_DV1 : ALU_MP1;
    endfunction

endpackage

// File: rtl/alu_sequencer_rr_arb2.sv
// Two-way round-robin arbiter; r_prio names the requester favoured on a tie.
// The pointer moves to the other requester only when a grant is accepted.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_accept,
    output logic o_gnt0,
    output logic o_gnt1
);

    logic r_prio;

    always_comb begin
        o_gnt0 = i_valid0 & (~i_valid1 | ~r_prio);
        o_gnt1 = i_valid1 & (~i_valid0 |  r_prio);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_accept) begin
            r_prio <= o_gnt0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Front end for a shared combinational ALU: arbitrates two requesters, issues
// one or two ALU commands per operation and returns a tagged response.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OPW  = 16,
    parameter int RESW = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [2:0]      req0_op,
    input  logic [OPW-1:0]  req0_a,
    input  logic [OPW-1:0]  req0_b,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [2:0]      req1_op,
    input  logic [OPW-1:0]  req1_a,
    input  logic [OPW-1:0]  req1_b,
    output logic [OPW-1:0]  alu_a,
    output logic [OPW-1:0]  alu_b,
    output logic [2:0]      alu_command,
    input  logic [RESW-1:0] alu_result,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [RESW-1:0] rsp_hi,
    output logic [RESW-1:0] rsp_lo,
    output logic            rsp_err
);

    state_e          r_state;
    state_e          w_next;
    logic [2:0]      r_op;
    logic [OPW-1:0]  r_a;
    logic [OPW-1:0]  r_b;
    logic            r_id;
    logic [RESW-1:0] r_hi;
    logic [RESW-1:0] r_lo;
    logic            r_err;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_accept;
    logic [2:0]      w_op;
    logic [OPW-1:0]  w_a;
    logic [OPW-1:0]  w_b;
    logic            w_illegal;
    logic            w_divz;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_accept (w_accept),
        .o_gnt0   (w_gnt0),
        .o_gnt1   (w_gnt1)
    );

    always_comb begin
        w_accept   = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);
        req0_ready = (r_state == S_IDLE) & w_gnt0;
        req1_ready = (r_state == S_IDLE) & w_gnt1;
        w_op       = w_gnt1 ? req1_op : req0_op;
        w_a        = w_gnt1 ? req1_a  : req0_a;
        w_b        = w_gnt1 ? req1_b  : req0_b;
        w_illegal  = (w_op > OP_DIV);
        // A divisor of 0 or 1 in the upper bits is treated as divide by zero.
        w_divz     = (w_op == OP_DIV) && (w_b[OPW-1:1] == '0);
    end

    always_comb begin
        w_next      = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_command = ALU_ADD;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_illegal || w_divz) ? S_RESP : S_EXEC1;
                end
            end
            S_EXEC1: begin
                alu_a       = r_a;
                alu_b       = r_b;
                alu_command = first_cmd(r_op);
                w_next      = is_two_pass(r_op) ? S_EXEC2 : S_RESP;
            end
            S_EXEC2: begin
                alu_a       = r_a;
                alu_b       = r_b;
                alu_command = second_cmd(r_op);
                w_next      = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_id  <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_a   <= w_a;
                        r_b   <= w_b;
                        r_id  <= w_gnt1;
                        r_err <= w_illegal | w_divz;
                        if (w_divz && !w_illegal) begin
                            r_hi <= RESW'(DIVZ_FILL);
                            r_lo <= RESW'(DIVZ_FILL);
                        end else begin
                            r_hi <= RESW'(ERR_FILL);
                            r_lo <= RESW'(ERR_FILL);
                        end
                    end
                end
                S_EXEC1: begin
                    if (is_two_pass(r_op)) begin
                        r_hi <= alu_result;
                    end else begin
                        r_lo <= alu_result;
                    end
                end
                S_EXEC2: r_lo <= alu_result;
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid = (r_state == S_RESP);
        rsp_id    = r_id;
        rsp_hi    = r_hi;
        rsp_lo    = r_lo;
        rsp_err   = r_err;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model.
// Inputs driven and outputs sampled 2-3 ns after the rising edge.
module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_op;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_op;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_command;
    logic [14:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [14:0] rsp_hi;
    logic [14:0] rsp_lo;
    logic        rsp_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    alu_sequencer #(.OPW(16), .RESW(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_op     (req0_op),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_op     (req1_op),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_command (alu_command),
        .alu_result  (alu_result),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_hi      (rsp_hi),
        .rsp_lo      (rsp_lo),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_command)
            3'd3, 3'd5: alu_result = 15'h0AAA;
            3'd4, 3'd6: alu_result = 15'h0555;
            default:    alu_result = alu_a[15:1] + alu_b[15:1];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drop_reqs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [14:0] hi,
                             input logic [14:0] lo, input logic err);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_id"},    rsp_id, id);
        check({tag, "_hi"},    rsp_hi, hi);
        check({tag, "_lo"},    rsp_lo, lo);
        check({tag, "_err"},   rsp_err, err);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b1;
        #3;
        check("rst_valid", rsp_valid, 0);
        check("rst_hi",    rsp_hi, 0);
        check("rst_lo",    rsp_lo, 0);
        check("rst_err",   rsp_err, 0);
        check("rst_cmd",   alu_command, 0);
        check("rst_a",     alu_a, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // T1: single ADD from requester 0
        req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h0006; req0_b = 16'h0004;
        #1;
        check("t1_rdy0", req0_ready, 1);
        check("t1_rdy1", req1_ready, 0);
        tick();
        drop_reqs();
        #1;
        check("t1_cmd",  alu_command, 0);
        check("t1_alua", alu_a, 16'h0006);
        check("t1_alub", alu_b, 16'h0004);
        check("t1_nov",  rsp_valid, 0);
        tick();
        check_rsp("t1", 1'b0, 15'h0000, 15'h0005, 1'b0);
        check("t1_resp_alua", alu_a, 0);
        tick();
        check("t1_drop", rsp_valid, 0);

        // T2: MUL from requester 1
        req1_valid = 1'b1; req1_op = 3'd3; req1_a = 16'h0010; req1_b = 16'h0020;
        #1;
        check("t2_rdy1", req1_ready, 1);
        check("t2_rdy0", req0_ready, 0);
        tick();
        drop_reqs();
        #1;
        check("t2_cmd1", alu_command, 3);
        check("t2_alua1", alu_a, 16'h0010);
        tick();
        check("t2_cmd2", alu_command, 4);
        check("t2_alub2", alu_b, 16'h0020);
        check("t2_nov", rsp_valid, 0);
        tick();
        check_rsp("t2", 1'b1, 15'h0AAA, 15'h0555, 1'b0);
        tick();

        // T3: divide by zero, no ALU command, one-cycle latency
        req0_valid = 1'b1; req0_op = 3'd4; req0_a = 16'h0008; req0_b = 16'h0001;
        #1;
        check("t3_rdy0", req0_ready, 1);
        tick();
        drop_reqs();
        #1;
        check_rsp("t3", 1'b0, 15'h7FFF, 15'h7FFF, 1'b1);
        check("t3_cmd", alu_command, 0);
        tick();

        // Illegal op from requester 1
        req1_valid = 1'b1; req1_op = 3'd6; req1_a = 16'h1234; req1_b = 16'h5678;
        #1;
        check("ill_rdy1", req1_ready, 1);
        tick();
        drop_reqs();
        #1;
        check_rsp("ill", 1'b1, 15'h0000, 15'h0000, 1'b1);
        tick();

        // T4: contention, grants alternate 0,1,0,1
        req0_op = 3'd0; req0_a = 16'h0002; req0_b = 16'h0002;
        req1_op = 3'd0; req1_a = 16'h0008; req1_b = 16'h0006;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_rdy0", req0_ready, (i % 2) == 0);
            check("t4_rdy1", req1_ready, (i % 2) == 1);
            tick();
            tick();
            check("t4_id", rsp_id, (i % 2) == 1);
            check("t4_lo", rsp_lo, ((i % 2) == 1) ? 15'd7 : 15'd2);
            check("t4_busy", req0_ready | req1_ready, 0);
            tick();
        end
        drop_reqs();

        // T5: backpressure on a SUB from requester 0
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h0014; req0_b = 16'h0006;
        #1;
        check("t5_rdy0", req0_ready, 1);
        tick();
        req1_valid = 1'b1;
        #1;
        check("t5_cmd", alu_command, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_rsp("t5_hold", 1'b0, 15'h0000, 15'h000D, 1'b0);
            check("t5_rdy0", req0_ready, 0);
            check("t5_rdy1", req1_ready, 0);
            tick();
        end
        drop_reqs();
        rsp_ready = 1'b1;
        #1;
        check("t5_last", rsp_valid, 1);
        tick();
        check("t5_drop", rsp_valid, 0);

        // T6: reset during EXEC2 of a DIV
        req1_valid = 1'b1; req1_op = 3'd4; req1_a = 16'h0028; req1_b = 16'h000A;
        #1;
        check("t6_rdy1", req1_ready, 1);
        tick();
        drop_reqs();
        #1;
        check("t6_cmd1", alu_command, 5);
        tick();
        check("t6_cmd2", alu_command, 6);
        rst_n = 1'b0;
        #1;
        check("t6_rst_cmd", alu_command, 0);
        check("t6_rst_a",   alu_a, 0);
        check("t6_rst_b",   alu_b, 0);
        check("t6_rst_v",   rsp_valid, 0);
        check("t6_rst_hi",  rsp_hi, 0);
        check("t6_rst_lo",  rsp_lo, 0);
        check("t6_rst_id",  rsp_id, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t6_norsp", rsp_valid, 0);
        end
        req0_valid = 1'b1; req0_op = 3'd2; req0_a = 16'h0006; req0_b = 16'h0004;
        #1;
        check("t6_rdy0", req0_ready, 1);
        tick();
        drop_reqs();
        #1;
        check("t6_and_cmd", alu_command, 2);
        tick();
        check_rsp("t6_after", 1'b0, 15'h0000, 15'h0005, 1'b0);
        tick();
        check("t6_drop", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
